inv_resp_checker: RTL and testbench
===================================

INV_RESP_CHECKER -- requirements
Module: inv_resp_checker

Interface
REQ-001 SHALL have parameter LAT, default 1, meaning DUT response latency in stim_valid beats (legal 0..7).
REQ-002 SHALL have parameter WINDOW, default 20, meaning the number of compared samples per run (legal 1..255).
REQ-003 SHALL have parameter CNT_W, default 8, meaning the counter width.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, which begins a run when sampled high in IDLE or DONE.
REQ-007 SHALL have port stim_valid, input, 1, which qualifies stim and resp on the same cycle.
REQ-008 SHALL have port stim, input, 1, the stimulus bit driven into the inverter DUT.
REQ-009 SHALL have port resp, input, 1, the observed DUT output bit.
REQ-010 SHALL have port busy, output, 1, which is high in FILL or CHECK.
REQ-011 SHALL have port done, output, 1, a one-cycle pulse on entry to DONE.
REQ-012 SHALL have port pass, output, 1, which is valid in DONE and is high iff err_cnt==0.
REQ-013 SHALL have port chk_cnt, output, CNT_W, the number of samples compared in the current or last run.
REQ-014 SHALL have port err_cnt, output, CNT_W, the number of mismatches, saturating at all-ones.
REQ-015 SHALL have port first_err_idx, output, CNT_W, the chk_cnt value at the first mismatch.

Function
REQ-016 SHALL implement states IDLE, FILL, CHECK and DONE.
REQ-017 SHALL, in IDLE or DONE with start=1, clear chk_cnt, err_cnt, first_err_idx, pass and the history, and enter FILL if LAT>0 or CHECK if LAT==0.
REQ-018 SHALL shift stim into a LAT-deep history register on each stim_valid=1 beat in FILL and CHECK only.
REQ-019 SHALL, in FILL, count stim_valid beats and enter CHECK after exactly LAT beats; no compares occur in FILL.
REQ-020 SHALL, in CHECK, compare each stim_valid beat as expected = ~(stim delayed LAT beats), where LAT==0 means the current stim.
REQ-021 SHALL, on each CHECK compare, increment chk_cnt and, if resp != expected, increment err_cnt (saturating).
REQ-022 SHALL enter DONE and pulse done on the cycle after the compare that makes chk_cnt == WINDOW.
REQ-023 SHALL have stim_valid=0 cycles cause no shift, no compare and no state change.
REQ-024 SHALL ignore start while busy=1.
REQ-025 SHALL, if start and stim_valid are both high in IDLE/DONE, use that cycle only to start; the beat is not shifted.
REQ-026 SHALL compute pass combinationally as (state==DONE) && (err_cnt==0); pass is 0 outside DONE.
REQ-027 SHALL hold counters in DONE until the next start.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, force state=IDLE, busy=0, done=0, pass=0, chk_cnt=0, err_cnt=0, first_err_idx=0 and history=0.
REQ-029 SHALL have rst take priority over start and stim_valid on the same cycle.
REQ-030 SHALL, on rst mid-run, abort the run with no done pulse.

Configuration
REQ-031 SHALL, with macro INV_CHK_FIRST_ERR_EN defined, capture chk_cnt (pre-increment) into first_err_idx on the first mismatch of a run and hold it until the next start or reset.
REQ-032 SHALL, without INV_CHK_FIRST_ERR_EN, tie first_err_idx to 0 and omit the capture register.

Verification
REQ-033 SHALL cover: LAT=1, WINDOW=20, DUT resp = ~stim registered by one beat, random stim every cycle -> done after 1+20 valid beats, err_cnt=0, pass=1, chk_cnt=20.
REQ-034 SHALL cover: same as REQ-033 with resp forced to stim on check beat index 5 only -> err_cnt=1, pass=0, first_err_idx=5 with the macro defined (0 without).
REQ-035 SHALL cover: LAT=0, WINDOW=4, resp=~stim combinational, stim_valid toggling every other cycle -> exactly 4 compares, done 1 cycle after the 4th valid beat, pass=1.
REQ-036 SHALL cover: resp stuck at 1, WINDOW=255, CNT_W=8, stim always 1 -> err_cnt=255 (saturated), pass=0.
REQ-037 SHALL cover: rst asserted after 7 compares -> next cycle state IDLE, all outputs 0, no done pulse; a new start then completes normally.
REQ-038 SHALL cover: start pulsed during CHECK -> ignored, with chk_cnt continuing uninterrupted to WINDOW.

Source files
------------

// File: rtl/inv_resp_checker.sv
// ---------------------------------------------------------------------------
// inv_resp_checker
//
// Scores a single-bit inverter DUT. Each qualified beat drives one stimulus
// bit into the DUT and observes one response bit. The checker keeps a short
// history of the stimulus so that the response, which trails the stimulus by
// LAT beats, is compared against the inverse of the matching stimulus bit.
// After WINDOW compares the run ends in DONE with a pass/fail verdict.
//
// Parameters
//   LAT     response latency in stim_valid beats (0..7)
//   WINDOW  number of compared samples per run (1..255)
//   CNT_W   width of the counters
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   start          begins a run when sampled high in IDLE or DONE
//   stim_valid     qualifies stim and resp on the same cycle
//   stim           stimulus bit driven into the inverter DUT
//   resp           observed DUT output bit
//   busy           high in FILL or CHECK
//   done           one-cycle pulse on entry to DONE
//   pass           high in DONE when no mismatch was seen
//   chk_cnt        samples compared in the current or last run
//   err_cnt        mismatches in the run, saturating at all-ones
//   first_err_idx  chk_cnt value at the first mismatch of the run
//
// Optional feature
//   INV_CHK_FIRST_ERR_EN  when defined, first_err_idx is captured on the first
//                         mismatch; otherwise it is tied to zero.
// ---------------------------------------------------------------------------
module inv_resp_checker #(
  parameter int LAT    = 1,
  parameter int WINDOW = 20,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stim_valid,
  input  logic             stim,
  input  logic             resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // History is at least one bit wide so LAT==0 still elaborates cleanly;
  // in that case the stored bit is never used for the expected value.
  localparam int               HW        = (LAT > 0) ? LAT : 1;
  localparam logic [2:0]       FILL_LAST = 3'((LAT > 0) ? (LAT - 1) : 0);
  localparam logic [CNT_W-1:0] WIN_C     = CNT_W'(WINDOW);

  logic [1:0]       state_q, state_d;
  logic [HW-1:0]    hist_q,  hist_d;
  logic [2:0]       fill_q,  fill_d;
  logic [CNT_W-1:0] chk_q,   chk_d;
  logic [CNT_W-1:0] err_q,   err_d;
  logic             done_q,  done_d;
`ifdef INV_CHK_FIRST_ERR_EN
  logic [CNT_W-1:0] first_q, first_d;
`endif

  logic [HW-1:0]    hist_shift;
  logic             exp_bit;
  logic             mismatch;
  logic [CNT_W-1:0] err_inc;
  logic [CNT_W-1:0] chk_inc;

  // Bit 0 holds the most recent stimulus, bit LAT-1 the one from LAT beats ago.
  always_comb begin
    hist_shift    = hist_q;
    hist_shift[0] = stim;
    for (int unsigned i = 1; i < HW; i++) begin
      hist_shift[i] = hist_q[i-1];
    end
  end

  always_comb begin
    exp_bit  = (LAT == 0) ? ~stim : ~hist_q[HW-1];
    mismatch = (resp != exp_bit);
    chk_inc  = chk_q + 1'b1;
    err_inc  = (err_q == '1) ? err_q : (err_q + 1'b1);
  end

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    chk_d   = chk_q;
    err_d   = err_q;
    done_d  = 1'b0;
`ifdef INV_CHK_FIRST_ERR_EN
    first_d = first_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        // A start cycle only launches the run; a coincident beat is dropped.
        if (start) begin
          hist_d  = '0;
          fill_d  = '0;
          chk_d   = '0;
          err_d   = '0;
`ifdef INV_CHK_FIRST_ERR_EN
          first_d = '0;
`endif
          state_d = (LAT == 0) ? S_CHECK : S_FILL;
        end
      end
      S_FILL: begin
        if (stim_valid) begin
          hist_d = hist_shift;
          if (fill_q == FILL_LAST) begin
            state_d = S_CHECK;
          end else begin
            fill_d = fill_q + 3'd1;
          end
        end
      end
      S_CHECK: begin
        if (stim_valid) begin
          hist_d = hist_shift;
          chk_d  = chk_inc;
          if (mismatch) begin
            err_d = err_inc;
`ifdef INV_CHK_FIRST_ERR_EN
            // err_cnt never returns to zero within a run, so zero marks "first".
            if (err_q == '0) begin
              first_d = chk_q;
            end
`endif
          end
          if (chk_inc == WIN_C) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      chk_q   <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

`ifdef INV_CHK_FIRST_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      first_q <= '0;
    end else begin
      first_q <= first_d;
    end
  end

  assign first_err_idx = first_q;
`else
  assign first_err_idx = '0;
`endif

  assign busy    = (state_q == S_FILL) || (state_q == S_CHECK);
  assign done    = done_q;
  assign pass    = (state_q == S_DONE) && (err_q == '0);
  assign chk_cnt = chk_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_inv_resp_checker.sv
module tb_inv_resp_checker;

  // Instance 0: LAT=1 WINDOW=20; instance 1: LAT=0 WINDOW=4;
  // instance 2: LAT=1 WINDOW=255. All use CNT_W=8.
  localparam int LATS [3] = '{1, 0, 1};
  localparam int WINS [3] = '{20, 4, 255};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start_v = '0;
  logic [2:0] valid_v = '0;
  logic [2:0] stim_v  = '0;
  logic [2:0] resp_v  = '0;
  logic [2:0] busy_v, done_v, pass_v;
  logic [7:0] chk_o   [3];
  logic [7:0] err_o   [3];
  logic [7:0] first_o [3];

  always #5 clk = ~clk;

  inv_resp_checker #(.LAT(1), .WINDOW(20), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .stim_valid(valid_v[0]),
    .stim(stim_v[0]), .resp(resp_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .chk_cnt(chk_o[0]), .err_cnt(err_o[0]),
    .first_err_idx(first_o[0]));

  inv_resp_checker #(.LAT(0), .WINDOW(4), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .stim_valid(valid_v[1]),
    .stim(stim_v[1]), .resp(resp_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .chk_cnt(chk_o[1]), .err_cnt(err_o[1]),
    .first_err_idx(first_o[1]));

  inv_resp_checker #(.LAT(1), .WINDOW(255), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .stim_valid(valid_v[2]),
    .stim(stim_v[2]), .resp(resp_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pass(pass_v[2]), .chk_cnt(chk_o[2]), .err_cnt(err_o[2]),
    .first_err_idx(first_o[2]));

  int total = 0;
  int bad   = 0;

  // Reference model: counts beats since start and compares beat j against
  // the stimulus recorded at beat j-LAT.
  bit m_act   [3];
  bit m_fin   [3];
  bit m_done  [3];
  int m_beats [3];
  int m_chk   [3];
  int m_err   [3];
  int m_first [3];
  bit m_hist  [3][300];
  bit done_seen [3];

  // Behaviour of the inverter DUT on instance 0: ~stim registered by one beat.
  logic inv_a    = 1'b0;
  int   force_idx = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 0; m_fin[i] = 0; m_done[i] = 0;
      m_beats[i] = 0; m_chk[i] = 0; m_err[i] = 0; m_first[i] = 0;
    end
  endtask

  task automatic step();
    logic [2:0] s_start, s_valid, s_stim, s_resp;
    logic       s_rst;
    // Responses of the DUTs under test for this cycle.
    resp_v[0] = inv_a;
    if (force_idx >= 0 && m_act[0] && valid_v[0] && m_beats[0] >= LATS[0]
        && m_chk[0] == force_idx)
      resp_v[0] = ~inv_a;
    resp_v[1] = ~stim_v[1];
    resp_v[2] = 1'b1;
    s_start = start_v; s_valid = valid_v; s_stim = stim_v; s_resp = resp_v; s_rst = rst;
    @(posedge clk);
    #1;
    if (s_valid[0]) inv_a = ~s_stim[0];
    for (int i = 0; i < 3; i++) begin
      m_done[i] = 0;
      if (s_rst) begin
        m_act[i] = 0; m_fin[i] = 0; m_beats[i] = 0;
        m_chk[i] = 0; m_err[i] = 0; m_first[i] = 0;
      end else if (!m_act[i]) begin
        if (s_start[i]) begin
          m_act[i] = 1; m_fin[i] = 0; m_beats[i] = 0;
          m_chk[i] = 0; m_err[i] = 0; m_first[i] = 0;
        end
      end else if (s_valid[i]) begin
        m_hist[i][m_beats[i]] = s_stim[i];
        if (m_beats[i] >= LATS[i]) begin
          if (s_resp[i] != ~m_hist[i][m_beats[i] - LATS[i]]) begin
            if (m_err[i] == 0) m_first[i] = m_chk[i];
            if (m_err[i] < 255) m_err[i]++;
          end
          m_chk[i]++;
          if (m_chk[i] == WINS[i]) begin
            m_act[i] = 0; m_fin[i] = 1; m_done[i] = 1;
          end
        end
        m_beats[i]++;
      end
      if (done_v[i] === 1'b1) done_seen[i] = 1;
      chk($sformatf("busy%0d", i), busy_v[i], m_act[i]);
      chk($sformatf("done%0d", i), done_v[i], m_done[i]);
      chk($sformatf("pass%0d", i), pass_v[i], (m_fin[i] && m_err[i] == 0));
      chk($sformatf("chk_cnt%0d", i), chk_o[i], m_chk[i]);
      chk($sformatf("err_cnt%0d", i), err_o[i], m_err[i]);
`ifdef INV_CHK_FIRST_ERR_EN
      chk($sformatf("first_err_idx%0d", i), first_o[i], m_first[i]);
`else
      chk($sformatf("first_err_idx%0d", i), first_o[i], 0);
`endif
    end
  endtask

  task automatic idle_inputs();
    start_v = '0; valid_v = '0; stim_v = '0;
  endtask

  initial begin
    model_reset();
    // Reset state, with start and valid asserted to confirm rst wins.
    rst = 1'b1; start_v = '1; valid_v = '1;
    step();
    idle_inputs();
    step();
    rst = 1'b0;
    step();

    // Clean run on instance 0: 1 fill beat + 20 compares, random stim.
    start_v[0] = 1'b1; step(); start_v[0] = 1'b0;
    done_seen[0] = 0;
    for (int n = 0; n < 40 && !m_fin[0]; n++) begin
      valid_v[0] = 1'b1; stim_v[0] = 1'($urandom);
      step();
    end
    idle_inputs();
    chk("a_clean_done_seen", done_seen[0], 1);
    chk("a_clean_pass", pass_v[0], 1);
    step();

    // Mismatch injected at check index 5.
    force_idx = 5;
    start_v[0] = 1'b1; step(); start_v[0] = 1'b0;
    done_seen[0] = 0;
    for (int n = 0; n < 40 && !m_fin[0]; n++) begin
      valid_v[0] = 1'b1; stim_v[0] = 1'($urandom);
      step();
    end
    idle_inputs();
    force_idx = -1;
    chk("a_err_done_seen", done_seen[0], 1);
    chk("a_err_cnt", err_o[0], 1);
    step();

    // Start pulsed mid-CHECK is ignored; random gaps in stim_valid.
    start_v[0] = 1'b1; step(); start_v[0] = 1'b0;
    done_seen[0] = 0;
    for (int n = 0; n < 100 && !m_fin[0]; n++) begin
      valid_v[0] = ($urandom_range(3) != 0);
      stim_v[0]  = 1'($urandom);
      start_v[0] = (m_chk[0] == 10 || m_chk[0] == 11);
      step();
    end
    idle_inputs();
    chk("a_ign_start_done_seen", done_seen[0], 1);
    chk("a_ign_start_chk_cnt", chk_o[0], 20);

    // Reset after 7 compares aborts the run with no done pulse.
    start_v[0] = 1'b1; step(); start_v[0] = 1'b0;
    done_seen[0] = 0;
    for (int n = 0; n < 30 && m_chk[0] < 7; n++) begin
      valid_v[0] = 1'b1; stim_v[0] = 1'($urandom);
      step();
    end
    rst = 1'b1; step(); rst = 1'b0;
    idle_inputs();
    step(); step();
    chk("a_abort_no_done", done_seen[0], 0);
    start_v[0] = 1'b1; step(); start_v[0] = 1'b0;
    for (int n = 0; n < 40 && !m_fin[0]; n++) begin
      valid_v[0] = 1'b1; stim_v[0] = 1'($urandom);
      step();
    end
    idle_inputs();
    chk("a_restart_done_seen", done_seen[0], 1);
    step();

    // Instance 1: LAT=0, stim_valid every other cycle.
    start_v[1] = 1'b1; valid_v[1] = 1'b1; stim_v[1] = 1'b1; step();
    start_v[1] = 1'b0;
    done_seen[1] = 0;
    for (int n = 0; n < 30 && !m_fin[1]; n++) begin
      valid_v[1] = n[0]; stim_v[1] = 1'($urandom);
      step();
    end
    idle_inputs();
    chk("b_done_seen", done_seen[1], 1);
    chk("b_chk_cnt", chk_o[1], 4);
    step(); step();

    // Instance 2: resp stuck at 1 with stim always 1, full 255-sample window.
    start_v[2] = 1'b1; step(); start_v[2] = 1'b0;
    done_seen[2] = 0;
    for (int n = 0; n < 300 && !m_fin[2]; n++) begin
      valid_v[2] = 1'b1; stim_v[2] = 1'b1;
      step();
    end
    idle_inputs();
    chk("c_done_seen", done_seen[2], 1);
    chk("c_err_cnt", err_o[2], 255);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
